// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM encoding and
// the sizing rule for the per-bit counter.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A one-bit operand still needs a counter bit to index its single step.
    function automatic int cnt_width(input int width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Single-bit full adder; the only arithmetic in the serial datapath.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a carry flop process the operands
// LSB first, one bit per clock, returning {cout,sum} = a + b + cin.
module serial_adder
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] res_next;
    logic [WIDTH:0]   res_cat;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_co;
    logic             last_bit;
    logic             accept;

    full_adder_cell u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // New sum bit enters at the MSB so the LSB-first result lands in order.
    assign res_cat  = {fa_s, res_sh};
    assign res_next = res_cat[WIDTH:1];
    assign last_bit = (cnt == LAST);
    assign accept   = ready && start;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: each combinational output gets a default before the case so no
    // path leaves it unassigned and a latch is never inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = start ? RUN : IDLE;
        endcase
    end

    // The unused encoding behaves as IDLE so a corrupted state self-recovers.
    always_comb begin
        ready = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state_q)
            RUN:     busy  = 1'b1;
            DONE:    done  = 1'b1;
            default: ready = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
        end else if (busy) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= res_next;
            carry  <= fa_co;
            cnt    <= cnt + CW'(1);
            if (last_bit) begin
                sum  <= res_next;
                cout <= fa_co;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: cycle-accurate expectation model for
// WIDTH=8 plus directed checks, and an exhaustive WIDTH=1 instance.
module tb_serial_adder;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;

    logic       start8 = 1'b0;
    logic [7:0] a8     = '0;
    logic [7:0] b8     = '0;
    logic       cin8   = 1'b0;
    logic       ready8, busy8, done8, cout8;
    logic [7:0] sum8;

    logic       start1 = 1'b0;
    logic [0:0] a1     = '0;
    logic [0:0] b1     = '0;
    logic       cin1   = 1'b0;
    logic       ready1, busy1, done1, cout1;
    logic [0:0] sum1;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Model state: cycles since the accept edge (-1 when idle) and results.
    int         m_cnt  = -1;
    logic [8:0] m_res  = '0;
    logic [7:0] m_sum  = '0;
    logic       m_cout = 1'b0;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .ready (ready8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .cin   (cin1),
        .ready (ready1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt  = -1;
            m_sum  = '0;
            m_cout = 1'b0;
        end else if (m_cnt < 0) begin
            if (start8) begin
                m_cnt = 0;
                m_res = 9'(a8) + 9'(b8) + 9'(cin8);
            end
        end else begin
            m_cnt++;
            if (m_cnt == 8) {m_cout, m_sum} = m_res;
            else if (m_cnt == 9) m_cnt = -1;
        end
    end

    always @(negedge clk) begin
        check("cycle", {ready8, busy8, done8, cout8, sum8},
              {(m_cnt < 0), (m_cnt >= 0 && m_cnt < 8), (m_cnt == 8), m_cout, m_sum});
    end

    task automatic add8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                        input logic [8:0] exp, input string nm);
        int n;
        n = 0;
        while (!ready8 && n < 30) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_ready"}, ready8, 1);
        a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        n = 0;
        while (!done8 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_lat"}, n, 8);
        check({nm, "_res"}, {cout8, sum8}, exp);
    endtask

    task automatic wait_done8(output int n);
        n = 0;
        while (!done8 && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int         n;
        int         dn;
        logic [2:0] v;
        logic [7:0] ra, rb;
        logic       rc;

        repeat (3) @(negedge clk);
        check("reset8", {ready8, busy8, done8, cout8, sum8}, 12'h800);
        check("reset1", {ready1, busy1, done1, cout1, sum1}, 5'b10000);
        rst_n = 1'b1;
        @(negedge clk);

        add8(8'h3C, 8'h05, 1'b0, 9'h041, "basic");
        add8(8'hFF, 8'h01, 1'b0, 9'h100, "ovf1");
        add8(8'hFF, 8'hFF, 1'b1, 9'h1FF, "ovf2");

        // Start pulses during RUN and DONE must be ignored.
        @(negedge clk);
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        wait_done8(n);
        check("busy_lat", n, 4);
        check("busy_res", {cout8, sum8}, 9'h030);
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        dn = 0;
        for (int i = 0; i < 12; i++) begin
            if (done8) dn++;
            @(negedge clk);
        end
        check("busy_extra_done", dn, 0);
        check("busy_hold", {cout8, sum8}, 9'h030);

        // Operands change right after the accept edge.
        a8 = 8'h81; b8 = 8'h7F; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        wait_done8(n);
        check("opchg_lat", n, 8);
        check("opchg_res", {cout8, sum8}, 9'h100);
        @(negedge clk);

        // Asynchronous reset in the middle of RUN.
        a8 = 8'h12; b8 = 8'h34; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check("rst_mid", {ready8, busy8, done8, cout8, sum8}, 12'h800);
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        for (int i = 0; i < 12; i++) begin
            if (done8) dn++;
            @(negedge clk);
        end
        check("rst_no_done", dn, 0);
        add8(8'h01, 8'h01, 1'b0, 9'h002, "post_rst");

        // WIDTH=1 exhaustive.
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            a1 = v[2]; b1 = v[1]; cin1 = v[0]; start1 = 1'b1;
            @(negedge clk);
            start1 = 1'b0;
            n = 0;
            while (!done1 && n < 10) begin
                @(negedge clk);
                n++;
            end
            check("w1_lat", n, 1);
            check("w1_res", {cout1, sum1}, 2'(v[2]) + 2'(v[1]) + 2'(v[0]));
            @(negedge clk);
        end

        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            add8(ra, rb, rc, 9'(ra) + 9'(rb) + 9'(rc), "rand");
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
